// File: rtl/text_console_writer.sv
// Character-stream to framebuffer-write converter for an 80x25 text display.
// Optional per-row clear on every y advance is enabled by defining TERM_CLEAR_LINE_EN.
module text_console_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 25,
  parameter int unsigned TABW  = 8,
  parameter logic [8:0]  BLANK = 9'h020
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_attr,
  output logic       we,
  output logic [6:0] wx,
  output logic [4:0] wy,
  output logic [8:0] wd,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y
);

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  localparam logic [7:0] ChBs  = 8'h08;
  localparam logic [7:0] ChTab = 8'h09;
  localparam logic [7:0] ChLf  = 8'h0A;
  localparam logic [7:0] ChFf  = 8'h0C;
  localparam logic [7:0] ChCr  = 8'h0D;
  localparam logic [7:0] ChDel = 8'h7F;

`ifdef TERM_CLEAR_LINE_EN
  typedef enum logic [1:0] {StIdle, StClrScr, StClrLin} state_e;
`else
  typedef enum logic [1:0] {StIdle, StClrScr} state_e;
`endif

  state_e     state_q, state_d;
  logic [6:0] cur_x_q, cur_x_d;
  logic [4:0] cur_y_q, cur_y_d;
  logic [6:0] sx_q, sx_d;
  logic [4:0] sy_q, sy_d;
  // Set while a sweep has been entered but its first cell is not yet written.
  logic       first_q, first_d;
  logic       ready_q, ready_d;
  logic       we_q, we_d;
  logic [6:0] wx_q, wx_d;
  logic [4:0] wy_q, wy_d;
  logic [8:0] wd_q, wd_d;

  logic       accept;
  logic       is_print;
  logic       y_adv;
  logic [4:0] y_inc;
  logic [7:0] tab_x;

  assign accept   = (state_q == StIdle) && ready_q && in_valid;
  assign is_print = (in_char >= 8'h20) && (in_char != ChDel);
  assign y_inc    = (cur_y_q == YMAX) ? 5'd0 : cur_y_q + 5'd1;
  assign tab_x    = ({1'b0, cur_x_q} | 8'(TABW - 1)) + 8'd1;
  assign y_adv    = accept && ((is_print && (cur_x_q == XMAX)) || (in_char == ChLf) ||
                               ((in_char == ChTab) && (tab_x >= 8'(COLS))));

  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    first_d = first_q;
    we_d    = 1'b0;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wd_d    = wd_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (y_adv) begin
            cur_y_d = y_inc;
          end
          if (is_print) begin
            we_d    = 1'b1;
            wx_d    = cur_x_q;
            wy_d    = cur_y_q;
            wd_d    = {in_attr, in_char};
            cur_x_d = (cur_x_q == XMAX) ? 7'd0 : cur_x_q + 7'd1;
          end else begin
            case (in_char)
              ChCr: cur_x_d = 7'd0;
              ChLf: cur_x_d = 7'd0;
              ChBs: begin
                if (cur_x_q != 7'd0) begin
                  cur_x_d = cur_x_q - 7'd1;
                  we_d    = 1'b1;
                  wx_d    = cur_x_q - 7'd1;
                  wy_d    = cur_y_q;
                  wd_d    = BLANK;
                end
              end
              ChTab: cur_x_d = y_adv ? 7'd0 : tab_x[6:0];
              ChFf: begin
                // First blank goes out with the accept so the sweep takes exactly ROWS*COLS cycles.
                state_d = StClrScr;
                cur_x_d = 7'd0;
                cur_y_d = 5'd0;
                sx_d    = 7'd0;
                sy_d    = 5'd0;
                first_d = 1'b0;
                we_d    = 1'b1;
                wx_d    = 7'd0;
                wy_d    = 5'd0;
                wd_d    = BLANK;
              end
              default: ;
            endcase
          end
`ifdef TERM_CLEAR_LINE_EN
          if (y_adv) begin
            state_d = StClrLin;
            sx_d    = 7'd0;
            first_d = 1'b1;
          end
`endif
        end
      end

      StClrScr: begin
        if (first_q) begin
          first_d = 1'b0;
          we_d    = 1'b1;
          wx_d    = sx_q;
          wy_d    = sy_q;
          wd_d    = BLANK;
        end else if ((sx_q == XMAX) && (sy_q == YMAX)) begin
          state_d = StIdle;
        end else begin
          if (sx_q == XMAX) begin
            sx_d = 7'd0;
            sy_d = sy_q + 5'd1;
          end else begin
            sx_d = sx_q + 7'd1;
          end
          we_d = 1'b1;
          wx_d = sx_d;
          wy_d = sy_d;
          wd_d = BLANK;
        end
      end

`ifdef TERM_CLEAR_LINE_EN
      StClrLin: begin
        if (first_q) begin
          first_d = 1'b0;
          sx_d    = 7'd0;
          we_d    = 1'b1;
          wx_d    = 7'd0;
          wy_d    = cur_y_q;
          wd_d    = BLANK;
        end else if (sx_q == XMAX) begin
          state_d = StIdle;
        end else begin
          sx_d = sx_q + 7'd1;
          we_d = 1'b1;
          wx_d = sx_d;
          wy_d = cur_y_q;
          wd_d = BLANK;
        end
      end
`endif

      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClrScr;
      cur_x_q <= 7'd0;
      cur_y_q <= 5'd0;
      sx_q    <= 7'd0;
      sy_q    <= 5'd0;
      first_q <= 1'b1;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wx_q    <= 7'd0;
      wy_q    <= 5'd0;
      wd_q    <= 9'd0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      first_q <= first_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wd_q    <= wd_d;
    end
  end

  assign in_ready = ready_q;
  assign we       = we_q;
  assign wx       = wx_q;
  assign wy       = wy_q;
  assign wd       = wd_q;
  assign cur_x    = cur_x_q;
  assign cur_y    = cur_y_q;

endmodule
